// File: rtl/spi_ctrl_regs.sv
// SPI mode-0 slave with a small control register file, fully in the clk domain.
// Writes land in shadow registers; live outputs follow immediately or on frame_start.
module spi_ctrl_regs #(
  parameter bit          VSYNC_COMMIT = 1'b1,
  parameter logic [7:0]  ID_VALUE     = 8'hD5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SCLK,
  input  logic       SSEL,
  input  logic       MOSI,
  input  logic       frame_start,
  output logic       MISO,
  output logic [7:0] background_state,
  output logic [5:0] solid_color,
  output logic       audio_en
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t     state;
  logic [2:0] sclk_sync;
  logic [2:0] ssel_sync;
  logic [1:0] mosi_sync;
  logic [2:0] bit_cnt;
  logic [7:0] cmd_sr;
  logic [6:0] data_sr;
  logic [6:0] rd_sr;

  logic [7:0] bg_sh, bg_nx;
  logic [5:0] sc_sh, sc_nx;
  logic       ae_sh, ae_nx;
  logic [7:0] wr_count;

  logic       sclk_rise, sclk_fall, ssel_rise, ssel_fall, mosi_bit;
  logic [7:0] cmd_next, wr_data;
  logic       wr_en, wr_hit;

  function automatic logic [7:0] read_reg(input logic [6:0] addr);
    case (addr)
      7'd0:    return bg_sh;
      7'd1:    return {2'b00, sc_sh};
      7'd2:    return {7'd0, ae_sh};
      7'd3:    return ID_VALUE;
      7'd4:    return wr_count;
      default: return 8'h00;
    endcase
  endfunction

  // Synchronizers start low so a select already held low at reset release never looks like a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      ssel_sync <= '0;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], SCLK};
      ssel_sync <= {ssel_sync[1:0], SSEL};
      mosi_sync <= {mosi_sync[0], MOSI};
    end
  end

  always_comb begin
    sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    ssel_rise = ssel_sync[1] & ~ssel_sync[2];
    ssel_fall = ~ssel_sync[1] & ssel_sync[2];
    mosi_bit  = mosi_sync[1];
    cmd_next  = {cmd_sr[6:0], mosi_bit};
    wr_data   = {data_sr, mosi_bit};
    wr_en     = (state == DATA) && sclk_rise && !ssel_rise && (bit_cnt == 3'd7) && !cmd_sr[7];
  end

  always_comb begin
    bg_nx  = bg_sh;
    sc_nx  = sc_sh;
    ae_nx  = ae_sh;
    wr_hit = 1'b0;
    if (wr_en) begin
      case (cmd_sr[6:0])
        7'd0:    begin bg_nx = wr_data;      wr_hit = 1'b1; end
        7'd1:    begin sc_nx = wr_data[5:0]; wr_hit = 1'b1; end
        7'd2:    begin ae_nx = wr_data[0];   wr_hit = 1'b1; end
        default: wr_hit = 1'b0;
      endcase
    end
  end

  // A commit on the write cycle takes the next-state values so the new data is not missed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bg_sh            <= '0;
      sc_sh            <= '0;
      ae_sh            <= 1'b0;
      wr_count         <= '0;
      background_state <= '0;
      solid_color      <= '0;
      audio_en         <= 1'b0;
    end else begin
      bg_sh <= bg_nx;
      sc_sh <= sc_nx;
      ae_sh <= ae_nx;
      if (wr_hit)
        wr_count <= wr_count + 8'd1;
      if (!VSYNC_COMMIT || frame_start) begin
        background_state <= bg_nx;
        solid_color      <= sc_nx;
        audio_en         <= ae_nx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      cmd_sr  <= '0;
      data_sr <= '0;
      rd_sr   <= '0;
      MISO    <= 1'b0;
    end else if (ssel_rise) begin
      state   <= IDLE;
      bit_cnt <= '0;
      MISO    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          MISO <= 1'b0;
          if (ssel_fall) begin
            state   <= CMD;
            bit_cnt <= '0;
          end
        end
        CMD: begin
          MISO <= 1'b0;
          if (sclk_rise) begin
            cmd_sr  <= cmd_next;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= DATA;
              if (cmd_next[7]) begin
                rd_sr <= read_reg(cmd_next[6:0])[6:0];
                MISO  <= read_reg(cmd_next[6:0])[7];
              end
            end
          end
        end
        DATA: begin
          if (sclk_rise) begin
            data_sr <= wr_data[6:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= DONE;
              MISO  <= 1'b0;
            end
          end else if (sclk_fall && cmd_sr[7] && bit_cnt != 3'd0) begin
            // The fall right after the command byte is skipped: bit 7 must hold until the first data rise.
            MISO  <= rd_sr[6];
            rd_sr <= {rd_sr[5:0], 1'b0};
          end
        end
        default: MISO <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ctrl_regs.sv
// Bench for spi_ctrl_regs: two instances (immediate and frame-synchronous commit) share the SPI pins.
module tb_spi_ctrl_regs;

  logic clk = 1'b0, rst_n = 1'b0;
  logic SCLK = 1'b0, SSEL = 1'b1, MOSI = 1'b0, frame_start = 1'b0;
  logic miso0, miso1, ae0, ae1;
  logic [7:0] bg0, bg1;
  logic [5:0] sc0, sc1;

  spi_ctrl_regs #(.VSYNC_COMMIT(1'b0), .ID_VALUE(8'hD5)) dut0 (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .SSEL(SSEL), .MOSI(MOSI),
    .frame_start(frame_start), .MISO(miso0), .background_state(bg0),
    .solid_color(sc0), .audio_en(ae0));

  spi_ctrl_regs #(.VSYNC_COMMIT(1'b1), .ID_VALUE(8'hD5)) dut1 (
    .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .SSEL(SSEL), .MOSI(MOSI),
    .frame_start(frame_start), .MISO(miso1), .background_state(bg1),
    .solid_color(sc1), .audio_en(ae1));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int stab_err = 0;

  logic [7:0]  m_bg, m_wc;
  logic [5:0]  m_sc;
  logic        m_ae;
  logic [14:0] live1;
  logic [14:0] snap0, snap1;
  logic [7:0]  exp_q[$];
  logic [15:0] got_q[$];

  function automatic logic [7:0] model_read(input logic [6:0] a);
    case (a)
      7'd0:    return m_bg;
      7'd1:    return {2'b00, m_sc};
      7'd2:    return {7'd0, m_ae};
      7'd3:    return 8'hD5;
      7'd4:    return m_wc;
      default: return 8'h00;
    endcase
  endfunction

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_clear();
    m_bg = '0; m_sc = '0; m_ae = 1'b0; m_wc = '0; live1 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    SSEL = 1'b1; SCLK = 1'b0; MOSI = 1'b0; frame_start = 1'b0;
    nclk(3);
    rst_n = 1'b1;
    model_clear();
    nclk(6);
  endtask

  task automatic check_reads(input string tag);
    logic [7:0] e;
    logic [15:0] g;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++;
      if (g[7:0] !== e || g[15:8] !== e) begin
        bad++;
        $display("FAIL %s got0=%h got1=%h want=%h", tag, g[7:0], g[15:8], e);
      end
    end
  endtask

  // Drives one frame; updates the model at the write, snapshots live outputs one clk after it.
  task automatic spi_frame(input logic [7:0] cmd, input logic [7:0] wd, input int nbits,
                           input int extra, input bit fs_on_wr);
    logic [15:0] word;
    logic [7:0]  r0, r1;
    logic        mr0, mr1;
    bit          do_wr;
    word  = {cmd, wd};
    r0 = '0; r1 = '0;
    do_wr = !cmd[7] && (nbits >= 16) && (cmd[6:0] <= 7'd2);
    if (cmd[7] && nbits >= 16) exp_q.push_back(model_read(cmd[6:0]));
    @(negedge clk);
    SSEL = 1'b0;
    nclk(6);
    for (int i = 0; i < nbits + extra; i++) begin
      MOSI = (i < 16) ? word[15 - i] : 1'b1;
      nclk(4);
      SCLK = 1'b1;
      mr0 = miso0; mr1 = miso1;
      if (i >= 8 && i < 16) begin
        r0 = {r0[6:0], miso0};
        r1 = {r1[6:0], miso1};
      end
      nclk(2);
      if (i < 16 && (miso0 !== mr0 || miso1 !== mr1)) stab_err++;
      if (i == 15 && do_wr) begin
        case (cmd[6:0])
          7'd0:    m_bg = wd;
          7'd1:    m_sc = wd[5:0];
          default: m_ae = wd[0];
        endcase
        m_wc = m_wc + 8'd1;
        if (fs_on_wr) frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        if (fs_on_wr) live1 = {m_bg, m_sc, m_ae};
        snap0 = {bg0, sc0, ae0};
        snap1 = {bg1, sc1, ae1};
        nclk(1);
      end else begin
        nclk(2);
      end
      SCLK = 1'b0;
    end
    nclk(4);
    SSEL = 1'b1;
    nclk(8);
    if (cmd[7] && nbits >= 16) got_q.push_back({r1, r0});
  endtask

  task automatic pulse_frame_start();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    live1 = {m_bg, m_sc, m_ae};
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({miso0, miso1, bg0, sc0, ae0, bg1, sc1, ae1} !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {miso0, miso1, bg0, sc0, ae0, bg1, sc1, ae1});
    end
    nclk(2);
    rst_n = 1'b1;
    model_clear();
    nclk(6);
    spi_frame(8'h84, 8'h00, 16, 0, 1'b0);
    check_reads("reset_wr_count");
  endtask

  task automatic test_write_live();
    spi_frame(8'h01, 8'hFF, 16, 0, 1'b0);
    total++;
    if (snap0 !== {m_bg, m_sc, m_ae}) begin
      bad++;
      $display("FAIL live0_solid got=%h want=%h", snap0, {m_bg, m_sc, m_ae});
    end
    total++;
    if (sc0 !== 6'h3F) begin
      bad++;
      $display("FAIL solid_color got=%h want=3f", sc0);
    end
    total++;
    if (snap1 !== live1) begin
      bad++;
      $display("FAIL live1_held got=%h want=%h", snap1, live1);
    end
    spi_frame(8'h81, 8'h00, 16, 0, 1'b0);
    spi_frame(8'h84, 8'h00, 16, 0, 1'b0);
    total++;
    if (got_q.size() != 2) begin
      bad++;
      $display("FAIL write_reads_count got=%0d want=2", got_q.size());
    end
    check_reads("write_readback");
  endtask

  task automatic test_vsync_commit();
    spi_frame(8'h00, 8'hA5, 16, 0, 1'b0);
    total++;
    if (snap1[14:7] !== 8'h00) begin
      bad++;
      $display("FAIL vsync_early got=%h want=00", snap1[14:7]);
    end
    nclk(20);
    total++;
    if (bg1 !== 8'h00) begin
      bad++;
      $display("FAIL vsync_hold got=%h want=00", bg1);
    end
    total++;
    if (bg0 !== 8'hA5) begin
      bad++;
      $display("FAIL live0_bg got=%h want=a5", bg0);
    end
    pulse_frame_start();
    total++;
    if ({bg1, sc1, ae1} !== live1) begin
      bad++;
      $display("FAIL vsync_commit got=%h want=%h", {bg1, sc1, ae1}, live1);
    end
    spi_frame(8'h02, 8'h01, 16, 0, 1'b1);
    total++;
    if (snap1 !== live1 || snap1[0] !== 1'b1) begin
      bad++;
      $display("FAIL same_cycle_commit got=%h want=%h", snap1, live1);
    end
  endtask

  task automatic test_read_id();
    stab_err = 0;
    spi_frame(8'h83, 8'h00, 16, 0, 1'b0);
    spi_frame(8'hFF, 8'h00, 16, 0, 1'b0);
    spi_frame(8'h82, 8'h00, 16, 0, 1'b0);
    total++;
    if (stab_err != 0) begin
      bad++;
      $display("FAIL miso_stable got=%0d want=0", stab_err);
    end
    total++;
    if (got_q.size() != 3) begin
      bad++;
      $display("FAIL read_count got=%0d want=3", got_q.size());
    end
    check_reads("read_data");
  endtask

  task automatic test_abort();
    spi_frame(8'h00, 8'h77, 12, 0, 1'b0);
    nclk(4);
    total++;
    if (bg0 !== m_bg) begin
      bad++;
      $display("FAIL abort_bg got=%h want=%h", bg0, m_bg);
    end
    spi_frame(8'h84, 8'h00, 16, 0, 1'b0);
    spi_frame(8'h00, 8'h5A, 16, 0, 1'b0);
    total++;
    if (snap0 !== {m_bg, m_sc, m_ae} || bg0 !== 8'h5A) begin
      bad++;
      $display("FAIL after_abort got=%h want=%h", snap0, {m_bg, m_sc, m_ae});
    end
    spi_frame(8'h84, 8'h00, 16, 0, 1'b0);
    check_reads("abort_wr_count");
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 256; k++)
      spi_frame({1'b0, 7'(k % 3)}, 8'($urandom_range(0, 255)), 16, 0, 1'b0);
    for (int k = 0; k < 3; k++)
      spi_frame(8'h03, 8'h12, 16, 0, 1'b0);
    spi_frame(8'h84, 8'h00, 16, 0, 1'b0);
    spi_frame(8'h83, 8'h00, 16, 0, 1'b0);
    total++;
    if (m_wc !== 8'h00) begin
      bad++;
      $display("FAIL wrap_model got=%h want=00", m_wc);
    end
    check_reads("wrap_read");
  endtask

  task automatic test_extra_pulses();
    spi_frame(8'h00, 8'h3C, 16, 20, 1'b0);
    total++;
    if (bg0 !== 8'h3C) begin
      bad++;
      $display("FAIL extra_bg got=%h want=3c", bg0);
    end
    spi_frame(8'h84, 8'h00, 16, 0, 1'b0);
    spi_frame(8'h80, 8'h00, 16, 0, 1'b0);
    check_reads("extra_read");
  endtask

  task automatic test_reset_mid_read();
    logic [15:0] word;
    spi_frame(8'h00, 8'h81, 16, 0, 1'b1);
    @(negedge clk);
    SSEL = 1'b0;
    nclk(6);
    word = 16'h8300;
    for (int i = 0; i < 9; i++) begin
      MOSI = word[15 - i];
      nclk(4); SCLK = 1'b1;
      nclk(4); SCLK = 1'b0;
    end
    nclk(4);
    total++;
    if (miso0 !== 1'b1 || miso1 !== 1'b1) begin
      bad++;
      $display("FAIL mid_read_miso got=%b%b want=11", miso0, miso1);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({miso0, miso1, bg0, sc0, ae0, bg1, sc1, ae1} !== 32'd0) begin
      bad++;
      $display("FAIL async_reset got=%h want=0", {miso0, miso1, bg0, sc0, ae0, bg1, sc1, ae1});
    end
    nclk(2);
    rst_n = 1'b1;
    model_clear();
    word = 16'h00FF;
    for (int i = 0; i < 16; i++) begin
      MOSI = word[15 - i];
      nclk(4); SCLK = 1'b1;
      nclk(4); SCLK = 1'b0;
    end
    nclk(6);
    total++;
    if ({bg0, bg1} !== 16'h0000) begin
      bad++;
      $display("FAIL partial_after_reset got=%h want=0000", {bg0, bg1});
    end
    SSEL = 1'b1;
    nclk(8);
    spi_frame(8'h84, 8'h00, 16, 0, 1'b0);
    check_reads("post_reset_count");
  endtask

  initial begin
    model_clear();
    snap0 = '0; snap1 = '0;
    nclk(2);
    test_reset();
    test_write_live();
    test_vsync_commit();
    test_read_id();
    test_abort();
    test_wrap();
    test_extra_pulses();
    test_reset_mid_read();
    total++;
    if (exp_q.size() != 0 || got_q.size() != 0) begin
      bad++;
      $display("FAIL queue_leftover got=%0d/%0d want=0/0", exp_q.size(), got_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50ms;
    bad++;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
